// File: rtl/fifo_sync_cntrl.sv
// fifo_sync_cntrl: pointer/flag controller for a single-clock FIFO built
// around an external memory with combinational read (show-ahead).
// Pointers carry one extra wrap bit so full and empty can be told apart.
// Optional sticky error flags are compiled in with FIFO_SYNC_CNTRL_ERR_EN;
// without it overflow/underflow read as 0 and err_clr is ignored.
module fifo_sync_cntrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int DATA_DEPTH   = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic                  rinc,
    input  logic                  err_clr,
    output logic                  wclken,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    // The pointer arithmetic only works for a power-of-two depth.
    if (DATA_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("fifo_sync_cntrl: DATA_DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [ADDR_WIDTH:0]   wptr_reg, wptr_next;
    logic [ADDR_WIDTH:0]   rptr_reg, rptr_next;
    logic [ADDR_WIDTH-1:0] lsb_match;
    logic                  push_ok;
    logic                  pop_ok;

    // Per-bit equality of the address portion of the two pointers.
    for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_lsb_match
        assign lsb_match[gi] = wptr_reg[gi] ~^ rptr_reg[gi];
    end

    // Status flags come from the registered pointers only.
    assign rempty      = (wptr_reg == rptr_reg);
    assign wfull       = (wptr_reg[ADDR_WIDTH] != rptr_reg[ADDR_WIDTH]) && (&lsb_match);
    assign fill_count  = wptr_reg - rptr_reg;
    assign almost_full = (int'(fill_count) >= AFULL_THRESH);

    assign waddr   = wptr_reg[ADDR_WIDTH-1:0];
    assign raddr   = rptr_reg[ADDR_WIDTH-1:0];
    assign push_ok = winc & ~wfull;
    assign pop_ok  = rinc & ~rempty;
    assign wclken  = push_ok;

    // Advance each pointer only for an accepted request; wraps naturally.
    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (push_ok) begin
            wptr_next = wptr_reg + 1'b1;
        end
        if (pop_ok) begin
            rptr_next = rptr_reg + 1'b1;
        end
    end

    // Pointer registers; reset wins over any request in the same cycle.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
        end
    end

`ifdef FIFO_SYNC_CNTRL_ERR_EN
    logic overflow_reg, overflow_next;
    logic underflow_reg, underflow_next;

    // Sticky flags: a new error beats a same-cycle clear.
    always_comb begin
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (err_clr) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (winc && wfull) begin
            overflow_next = 1'b1;
        end
        if (rinc && rempty) begin
            underflow_next = 1'b1;
        end
    end

    // Error flag registers.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_cntrl.sv
// tb_fifo_sync_cntrl: directed scenarios plus random traffic against a
// queue-based reference model. The bench owns a small memory driven by the
// DUT's wclken/waddr and read at raddr, so data order is checked end to end.
// Honours FIFO_SYNC_CNTRL_ERR_EN the same way the design does.
`timescale 1ns/1ps
module tb_fifo_sync_cntrl;

    localparam int AW     = 3;
    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;

    logic          wclk = 1'b0;
    logic          wrst = 1'b1;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    logic          err_clr = 1'b0;
    logic          wclken;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          wfull;
    logic          rempty;
    logic          almost_full;
    logic [AW:0]   fill_count;
    logic          overflow;
    logic          underflow;

    fifo_sync_cntrl #(
        .ADDR_WIDTH  (AW),
        .DATA_DEPTH  (DEPTH),
        .AFULL_THRESH(AFULL)
    ) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .winc       (winc),
        .rinc       (rinc),
        .err_clr    (err_clr),
        .wclken     (wclken),
        .waddr      (waddr),
        .raddr      (raddr),
        .wfull      (wfull),
        .rempty     (rempty),
        .almost_full(almost_full),
        .fill_count (fill_count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 wclk = ~wclk;

    // Reference model: contents as a queue, addresses from lifetime counts.
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_q[$];
    int          m_wr_total = 0;
    int          m_rd_total = 0;
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    logic [31:0] tb_mem [DEPTH];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wr_total = 0;
        m_rd_total = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock cycle: drive, check the cycle's outputs, then advance the model.
    task automatic step(input bit w, input bit r, input bit c, input bit rs);
        int          fill;
        bit          m_full, m_empty, push_ok, pop_ok;
        logic [31:0] data;
        @(negedge wclk);
        winc = w; rinc = r; err_clr = c; wrst = rs;
        #1;
        fill    = m_q.size();
        m_full  = (fill == DEPTH);
        m_empty = (fill == 0);
        push_ok = w && !m_full;
        pop_ok  = r && !m_empty;
        check_value("fill_count", 32'(fill_count), 32'(fill));
        check_value("rempty", 32'(rempty), 32'(m_empty));
        check_value("wfull", 32'(wfull), 32'(m_full));
        check_value("almost_full", 32'(almost_full), 32'(fill >= AFULL));
        check_value("waddr", 32'(waddr), 32'(m_wr_total % DEPTH));
        check_value("raddr", 32'(raddr), 32'(m_rd_total % DEPTH));
        check_value("wclken", 32'(wclken), 32'(push_ok));
`ifdef FIFO_SYNC_CNTRL_ERR_EN
        check_value("overflow", 32'(overflow), 32'(m_ovf));
        check_value("underflow", 32'(underflow), 32'(m_unf));
`else
        check_value("overflow", 32'(overflow), 32'd0);
        check_value("underflow", 32'(underflow), 32'd0);
`endif
        if (pop_ok && !rs && m_q.size() > 0) begin
            check_value("read_data", tb_mem[raddr], m_q[0]);
            $display("pop  data=%08h addr=%0d fill=%0d", tb_mem[raddr], raddr, fill);
        end
        data = $urandom;
        @(posedge wclk);
        // Memory write happens on the same edge, as a real RAM would.
        if (wclken && !rs) tb_mem[waddr] = data;
        if (rs) begin
            model_reset();
        end else begin
            m_ovf = (w && m_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_unf = (r && m_empty) ? 1'b1 : (c ? 1'b0 : m_unf);
            if (pop_ok) begin
                void'(m_q.pop_front());
                m_rd_total++;
            end
            if (push_ok) begin
                m_q.push_back(data);
                m_wr_total++;
                $display("push data=%08h fill=%0d", data, m_q.size());
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge wclk);
        model_reset();
        // Reset held, then idle.
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        // Fill completely: almost_full after the 6th, full after the 8th.
        repeat (8) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        // Push+pop while full: only the pop is taken.
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        // Drain, then pop on empty.
        repeat (7) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Clear and a new error together: flag stays set.
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        // Push+pop on empty: push only, no bypass.
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        // Hold at fill 3 for 20 cycles of push+pop; pointers wrap.
        repeat (3) step(1, 0, 0, 0);
        repeat (20) step(1, 1, 0, 0);
        // Reach fill 5 and reset with winc held.
        repeat (2) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);
        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
        end
        step(0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_sync_cntrl.md
FIFO_SYNC_CNTRL -- requirements
Module: fifo_sync_cntrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, memory address width.
REQ-002 SHALL have parameter DATA_DEPTH, default 8, entries; SHALL equal 2**ADDR_WIDTH.
REQ-003 SHALL have parameter AFULL_THRESH, default 6, fill level at or above which almost_full asserts.
REQ-004 SHALL have port wclk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port wrst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port winc  input  1  push request.
REQ-007 SHALL have port rinc  input  1  pop request.
REQ-008 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-009 SHALL have port wclken  output  1  memory write enable.
REQ-010 SHALL have port waddr  output  ADDR_WIDTH  memory write address.
REQ-011 SHALL have port raddr  output  ADDR_WIDTH  memory read address; memory read is combinational.
REQ-012 SHALL have port wfull  output  1  FIFO full.
REQ-013 SHALL have port rempty  output  1  FIFO empty.
REQ-014 SHALL have port almost_full  output  1  fill_count >= AFULL_THRESH.
REQ-015 SHALL have port fill_count  output  ADDR_WIDTH+1  stored entries, 0..DATA_DEPTH.
REQ-016 SHALL have port overflow  output  1  sticky: push attempted while full.
REQ-017 SHALL have port underflow  output  1  sticky: pop attempted while empty.

Function
REQ-018 SHALL keep write and read pointers of ADDR_WIDTH+1 bits, binary; waddr/raddr = pointer LSBs.
REQ-019 SHALL accept a push when winc=1 and wfull=0; wclken = winc & ~wfull, combinational, same cycle.
REQ-020 SHALL increment write pointer on the edge ending an accepted-push cycle; wrap modulo 2**(ADDR_WIDTH+1).
REQ-021 SHALL accept a pop when rinc=1 and rempty=0; data at raddr is valid during that cycle (show-ahead); read pointer increments on that edge.
REQ-022 SHALL derive rempty = (wptr == rptr), from registered pointers only.
REQ-023 SHALL derive wfull = (MSBs differ and LSBs equal), from registered pointers only.
REQ-024 SHALL compute fill_count = wptr - rptr modulo 2**(ADDR_WIDTH+1).
REQ-025 Simultaneous push and pop, neither full nor empty: both accepted, fill_count unchanged.
REQ-026 Push and pop while full: pop accepted, push rejected, wclken=0, overflow sets.
REQ-027 Push and pop while empty: push accepted, pop rejected, underflow sets; no same-cycle bypass.
REQ-028 Rejected requests SHALL not move any pointer.
REQ-029 overflow/underflow SHALL set on the edge after the offending cycle and hold until err_clr or reset; err_clr and a new error in the same cycle: flag remains set.

Reset
REQ-030 On wrst=1 at a rising edge: both pointers 0, overflow=0, underflow=0.
REQ-031 After reset: rempty=1, wfull=0, almost_full=0 (AFULL_THRESH>0), fill_count=0, waddr=raddr=0.
REQ-032 Reset asserted mid-traffic SHALL override winc/rinc in that cycle; memory contents are not cleared by this block.

Configuration
REQ-033 Macro FIFO_SYNC_CNTRL_ERR_EN defined: overflow/underflow and err_clr behave per REQ-016/017/029.
REQ-034 Macro undefined: overflow and underflow tied to 0, err_clr ignored, no error registers; all other behaviour identical.

Verification
REQ-035 Reset, then idle 3 cycles -> rempty=1, wfull=0, fill_count=0, waddr=raddr=0.
REQ-036 8 consecutive pushes (defaults) -> wclken high 8 cycles, almost_full=1 after 6th push, wfull=1 and fill_count=8 after 8th.
REQ-037 Full, assert winc+rinc one cycle -> wclken=0, raddr 0->1, fill_count=7, overflow=1 (ERR_EN).
REQ-038 Empty, pop -> raddr unchanged, rempty=1, underflow=1; err_clr pulse -> underflow=0.
REQ-039 20 push/pop cycles with fill at 3 -> pointers wrap past 15, fill_count stays 3, read order matches write order.
REQ-040 wrst=1 with fill_count=5 and winc=1 -> next cycle fill_count=0, rempty=1, no pointer advance.
